// File: rtl/armleo_mem_pkg.sv
// Shared types and helpers for the armleo_mem family of lane-masked RAMs.
package armleo_mem_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } clear_state_t;

    function automatic int unsigned lanes_from_width(input int unsigned width,
                                                     input int unsigned granulity);
        return width / granulity;
    endfunction

endpackage

// File: rtl/armleo_mem_1r1w.sv
// Single-lane storage: one write port, one registered read port, read-first on collision.
module armleo_mem_1r1w #(
    parameter int unsigned DEPTH_LOG2 = 7,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  read,
    input  logic [DEPTH_LOG2-1:0] read_address,
    output logic [WIDTH-1:0]      readdata,
    input  logic                  write,
    input  logic [DEPTH_LOG2-1:0] write_address,
    input  logic [WIDTH-1:0]      writedata
);

    logic [WIDTH-1:0] storage [2**DEPTH_LOG2];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (write) begin
            storage[write_address] <= writedata;
        end
        if (read) begin
            rdata_q <= storage[read_address];
        end
    end

    assign readdata = rdata_q;

endmodule

// File: rtl/armleo_mem_1r1wm.sv
// Lane-masked 1R1W RAM with write-first forwarding and optional output register.
// Define ARMLEO_MEM_INIT_CLEAR_EN to zero-fill the storage after every reset.
module armleo_mem_1r1wm
    import armleo_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 7,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned GRANULITY  = 8,
    parameter int unsigned OUTPUT_REG = 0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         read,
    input  logic [DEPTH_LOG2-1:0]                        read_address,
    output logic [WIDTH-1:0]                             readdata,
    output logic                                         readdatavalid,
    input  logic                                         write,
    input  logic [DEPTH_LOG2-1:0]                        write_address,
    input  logic [lanes_from_width(WIDTH, GRANULITY)-1:0] writeenable,
    input  logic [WIDTH-1:0]                             writedata,
    output logic                                         busy
);

    localparam int unsigned LANES = lanes_from_width(WIDTH, GRANULITY);

    if (WIDTH % GRANULITY != 0) begin : g_bad_granulity
        $fatal(1, "armleo_mem_1r1wm: WIDTH must be a multiple of GRANULITY");
    end

    logic                  clearing;
    logic [DEPTH_LOG2-1:0] clear_addr;

`ifdef ARMLEO_MEM_INIT_CLEAR_EN
    clear_state_t          state_q;
    logic [DEPTH_LOG2-1:0] counter_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            counter_q <= '0;
        end else if (state_q == StClear) begin
            counter_q <= counter_q + 1'b1;
            if (counter_q == '1) begin
                state_q <= StIdle;
            end
        end
    end

    assign clearing   = (state_q == StClear) && !rst;
    assign clear_addr = counter_q;
    assign busy       = rst || (state_q == StClear);
`else
    assign clearing   = 1'b0;
    assign clear_addr = '0;
    assign busy       = 1'b0;
`endif

    // Requests presented during reset are dropped as well as those seen while busy.
    logic read_acc, write_acc;
    assign read_acc  = read && !busy && !rst;
    assign write_acc = write && !busy && !rst;

    logic [LANES-1:0]      lane_we;
    logic [WIDTH-1:0]      lane_wdata;
    logic [DEPTH_LOG2-1:0] lane_waddr;
    logic [WIDTH-1:0]      mem_rdata;

    always_comb begin
        lane_waddr = clearing ? clear_addr : write_address;
        lane_wdata = clearing ? '0 : writedata;
        for (int k = 0; k < int'(LANES); k++) begin
            lane_we[k] = clearing || (write_acc && writeenable[k]);
        end
    end

    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        armleo_mem_1r1w #(
            .DEPTH_LOG2 (DEPTH_LOG2),
            .WIDTH      (GRANULITY)
        ) u_lane (
            .clk           (clk),
            .read          (read_acc),
            .read_address  (read_address),
            .readdata      (mem_rdata[k*GRANULITY +: GRANULITY]),
            .write         (lane_we[k]),
            .write_address (lane_waddr),
            .writedata     (lane_wdata[k*GRANULITY +: GRANULITY])
        );
    end

    // Lanes return old data on a collision, so remember which lanes the same-cycle write hit.
    logic [LANES-1:0] fwd_q;
    logic [WIDTH-1:0] fwd_data_q;
    logic             valid1_q;
    logic [WIDTH-1:0] merged;

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(LANES); k++) begin
            fwd_q[k] <= write_acc && writeenable[k] && (write_address == read_address);
        end
        fwd_data_q <= writedata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= read_acc;
        end
    end

    always_comb begin
        merged = mem_rdata;
        for (int k = 0; k < int'(LANES); k++) begin
            if (fwd_q[k]) begin
                merged[k*GRANULITY +: GRANULITY] = fwd_data_q[k*GRANULITY +: GRANULITY];
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic             valid2_q;
        logic [WIDTH-1:0] out_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid2_q <= 1'b0;
                out_q    <= '0;
            end else begin
                valid2_q <= valid1_q;
                if (valid1_q) begin
                    out_q <= merged;
                end
            end
        end

        assign readdata      = out_q;
        assign readdatavalid = valid2_q;
    end else begin : g_out_comb
        logic [WIDTH-1:0] hold_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
            end else if (valid1_q) begin
                hold_q <= merged;
            end
        end

        assign readdata      = valid1_q ? merged : hold_q;
        assign readdatavalid = valid1_q;
    end

endmodule
